// File: rtl/ahb_bridge_pkg.sv
// Shared types and helpers for the AHB-Lite to peripheral-slot bridge.
package ahb_bridge_pkg;

  typedef enum logic [2:0] {IDLE, ACCESS, DONE, ERR1, ERR2} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Byte-lane enables for a legal (already aligned) access of the given size.
  function automatic logic [3:0] wstrb(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      3'd0:    wstrb = 4'b0001 << addr;
      3'd1:    wstrb = 4'b0011 << {addr[1], 1'b0};
      default: wstrb = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/ahb_periph_decode.sv
// Combinational address-phase decode: slot index, one-hot select and legality flags.
module ahb_periph_decode
  import ahb_bridge_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter logic [7:0] SLOT_MASK = 8'h0F
) (
  input  logic [2:0]           slot_bits,
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           size,
  output logic [2:0]           slot,
  output logic [NUM_SLOTS-1:0] sel,
  output logic                 mapped,
  output logic                 aligned,
  output logic                 size_ok
);

  always_comb begin
    slot = slot_bits;
    sel  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sel[i] = SLOT_MASK[i] && (slot_bits == 3'(i));
    end
    mapped  = |sel;
    size_ok = (size <= 3'd2);
    case (size)
      3'd1:    aligned = ~addr_lo[0];
      3'd2:    aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_periph_bridge.sv
// AHB-Lite slave bridging one bus port to NUM_SLOTS ready-handshaked peripheral slots,
// with per-access timeout and two-cycle ERROR responses for illegal or stalled accesses.
module ahb_periph_bridge
  import ahb_bridge_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         NUM_SLOTS = 4,
  parameter int         SLOT_AW   = 8,
  parameter logic [7:0] SLOT_MASK = 8'h0F,
  parameter int         TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hsel,
  input  logic [ADDR_W-1:0]       haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [31:0]             hwdata,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [1:0]              hresp,
  output logic [31:0]             hrdata,
  output logic [NUM_SLOTS-1:0]    p_sel,
  output logic [SLOT_AW-1:0]      p_addr,
  output logic                    p_wr,
  output logic                    p_rd,
  output logic [3:0]              p_wstrb,
  output logic [31:0]             p_wdata,
  input  logic [NUM_SLOTS*32-1:0] p_rdata,
  input  logic [NUM_SLOTS-1:0]    p_ready
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t                 state, state_next;
  logic [SLOT_AW-1:0]     addr_q;
  logic                   write_q;
  logic [2:0]             size_q;
  logic [NUM_SLOTS-1:0]   sel_q;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;

  logic [2:0]             dec_slot;
  logic [NUM_SLOTS-1:0]   dec_sel;
  logic                   dec_mapped, dec_aligned, dec_size_ok;
  logic                   accept, good, slot_ready, timed_out;
  logic [31:0]            slot_rdata;
  logic                   unused_bits;

  ahb_periph_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_MASK (SLOT_MASK)
  ) u_decode (
    .slot_bits (haddr[SLOT_AW+2:SLOT_AW]),
    .addr_lo   (haddr[1:0]),
    .size      (hsize),
    .slot      (dec_slot),
    .sel       (dec_sel),
    .mapped    (dec_mapped),
    .aligned   (dec_aligned),
    .size_ok   (dec_size_ok)
  );

  assign unused_bits = ^{haddr[ADDR_W-1:SLOT_AW+3], htrans[0], dec_slot};

  // A new address phase is only taken while the previous data phase is completing or idle.
  assign accept    = (state inside {IDLE, DONE, ERR2}) && hsel && hready && htrans[1];
  assign good      = dec_mapped && dec_aligned && dec_size_ok;
  assign slot_ready = |(p_ready & sel_q);
  assign timed_out = (cnt >= CNT_LAST);
  assign hrdata    = rdata_q;

  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_q[i]) slot_rdata = slot_rdata | p_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_next = state;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    p_sel      = '0;
    p_addr     = '0;
    p_wr       = 1'b0;
    p_rd       = 1'b0;
    p_wstrb    = 4'h0;
    p_wdata    = 32'h0;
    case (state)
      ACCESS: begin
        hreadyout = 1'b0;
        p_sel     = sel_q;
        p_addr    = addr_q;
        p_wr      = write_q;
        p_rd      = ~write_q;
        if (write_q) begin
          p_wstrb = wstrb(size_q, addr_q[1:0]);
          p_wdata = (cnt == '0) ? hwdata : wdata_q;
        end
        // Ready wins over timeout when both land in the same cycle.
        if (slot_ready)     state_next = DONE;
        else if (timed_out) state_next = ERR1;
      end
      ERR1: begin
        hreadyout  = 1'b0;
        hresp      = HRESP_ERROR;
        state_next = ERR2;
      end
      default: begin
        if (state == ERR2) hresp = HRESP_ERROR;
        if (accept) state_next = good ? ACCESS : ERR1;
        else        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      sel_q   <= '0;
      cnt     <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= haddr[SLOT_AW-1:0];
        write_q <= hwrite;
        size_q  <= hsize;
        sel_q   <= dec_sel;
      end
      if (state != ACCESS)   cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (state == ACCESS && cnt == '0 && write_q) wdata_q <= hwdata;
      if (state == ACCESS && slot_ready && !write_q) rdata_q <= slot_rdata;
    end
  end

endmodule

// File: doc/ahb_periph_bridge.md
Name: ahb_periph_bridge

Overview:
- Parametrised AHB-Lite slave that bridges one AHB port to NUM_SLOTS simple peripheral slots (addr/wr/rd/strobe/ready).
- Each slot has its own ready handshake and a timeout.
- Unmapped, misaligned and timed-out accesses return a two-cycle AHB ERROR.
- Sits on an AHB matrix master port in front of UART/GPIO/timer-style peripherals.

Parameters:
- ADDR_W, 16, width of haddr.
- NUM_SLOTS, 4, number of peripheral slots (1..8).
- SLOT_AW, 8, byte-address bits per slot; slot index = haddr[SLOT_AW+2:SLOT_AW] (3 bits).
- SLOT_MASK, 8'h0F, bit i = 1 enables slot i; disabled or ≥NUM_SLOTS slots are unmapped.
- TIMEOUT, 255, max ACCESS cycles waiting for p_ready before ERROR (1..1023).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_W  address
- htrans  in  2  transfer type
- hwrite  in  1  write
- hsize  in  3  size
- hwdata  in  32  write data (data phase)
- hready  in  1  bus ready (matrix HREADYMUX)
- hreadyout  out  1  slave ready
- hresp  out  2  response (00 OKAY, 01 ERROR)
- hrdata  out  32  read data
- p_sel  out  NUM_SLOTS  one-hot slot select
- p_addr  out  SLOT_AW  byte address within slot
- p_wr  out  1  write strobe
- p_rd  out  1  read strobe
- p_wstrb  out  4  byte lanes
- p_wdata  out  32  write data
- p_rdata  in  NUM_SLOTS*32  per-slot read data, slot i at [32i+31:32i]
- p_ready  in  NUM_SLOTS  per-slot completion

Behaviour:
- Reset (async, any state, mid-transfer included): state=IDLE, hreadyout=1, hresp=00, hrdata=0, p_sel=0, p_wr=p_rd=0, p_wstrb=0, p_addr=0, p_wdata=0, timeout counter=0.
- Address-phase accept: hsel & hready & htrans[1]. Capture addr, hwrite, hsize and slot index.
- htrans IDLE/BUSY, or hsel=0: no action; hreadyout stays 1, OKAY.
- Error check at accept:
  - unmapped slot;
  - hsize>2;
  - hsize=1 with addr[0]=1;
  - hsize=2 with addr[1:0]≠0.
  - Any of these → ERR1 directly; no peripheral strobe is issued.
- FSM states:
  - IDLE: hreadyout=1. Good accept → ACCESS; bad accept → ERR1.
  - ACCESS: hreadyout=0. p_sel[slot]=1, p_addr=captured addr[SLOT_AW-1:0], p_wr/p_rd held.
    - Writes: p_wdata=hwdata; hwdata is sampled into a register on the first ACCESS cycle and held while waiting.
    - p_wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF.
    - p_ready[slot]=1 → DONE. On reads, hrdata ← p_rdata slot word on that edge.
    - Counter reaches TIMEOUT with no ready → strobes drop, go to ERR1.
  - DONE: hreadyout=1, hresp=00; strobes deasserted. A new accept in this cycle goes to ACCESS/ERR1; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=01 → ERR2.
  - ERR2: hreadyout=1, hresp=01. A new accept is honoured as in IDLE; otherwise → IDLE.
- Latency: minimum data phase is 2 cycles (ACCESS + DONE) when p_ready=1 on the first ACCESS cycle.
- Back-to-back: one transfer per 2 cycles.
- Timeout counter: clears on entry to ACCESS, saturates, width clog2(TIMEOUT+1).
- hrdata holds the last read value; it is unchanged by writes and errors.
- p_ready of non-selected slots is ignored. p_ready asserted in the same cycle the counter hits TIMEOUT counts as success.

Decomposition:
- Shared package ahb_bridge_pkg:
  - state enum {IDLE, ACCESS, DONE, ERR1, ERR2};
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants;
  - function wstrb(size, addr[1:0]).
- One sub-module ahb_periph_decode (combinational): slot index, one-hot select, mapped/aligned/size-valid flags from haddr/hsize/SLOT_MASK.

Test Plan:
- Word write 0xDEADBEEF to 0x0104, slot 1 p_ready=1 immediately → p_sel=0010, p_addr=0x04, p_wstrb=F, p_wdata=DEADBEEF for 1 cycle; hreadyout low 1 cycle; hresp=00.
- Byte read 0x0203, slot 2 p_ready after 3 cycles, p_rdata slot2=0x11223344 → hreadyout low 4 cycles; hrdata=0x11223344; p_rd high 4 cycles.
- Read 0x0500 (slot 5, unmapped) → no p_sel; hresp=01 for 2 cycles, hreadyout=0 then 1.
- Halfword write to 0x0001 → ERROR, no p_wr. Halfword write to 0x0002 → p_wstrb=1100.
- TIMEOUT=4, slot 0 never ready → 4 ACCESS cycles, then ERR1/ERR2; hrdata unchanged.
- Two back-to-back NONSEQ reads to slots 0 and 3 (both ready) → second accepted in DONE, 2-cycle spacing. Separately, assert rst_n=0 mid-ACCESS → all outputs return to reset values immediately.
